// File: rtl/ps2_digit_entry.sv
// ps2_digit_entry
//   Turns the PS/2 scan-code byte stream into a left-aligned BCD ID entry.
//   It decodes the E0 (extended) and F0 (break) prefixes and suppresses
//   typematic repeats. It handles the digit keys (main row and keypad),
//   Backspace, Esc (clear), Enter (normal or keypad) and Ctrl+A.
//
// Ports
//   CLK          in   system clock
//   reset        in   asynchronous, active-high reset
//   code_valid   in   one-cycle strobe, code_byte valid
//   code_byte    in   received scan-code byte
//   id_value     out  entered digits; first digit in the MS nibble, PAD_NIBBLE elsewhere
//   digit_count  out  number of digits entered
//   full         out  digit_count == NUM_DIGITS
//   key_valid    out  pulse on a newly accepted digit
//   key_value    out  last accepted digit, 4'hF after reset or Esc
//   entry_done   out  pulse on an accepted Enter
//   esc_pulse    out  pulse on Esc
//   ctrla_pulse  out  pulse on an A make while Ctrl is held
//   err_pulse    out  pulse on a rejected action
//   ctrl_held    out  a Ctrl key is currently down
//
// Parser states
//   state      | meaning
//   S_IDLE     | waiting for the first byte of a sequence
//   S_EXT      | E0 seen, next byte is an extended make (or F0)
//   S_BRK      | F0 seen, next byte is a normal break
//   S_EXT_BRK  | E0 F0 seen, next byte is an extended break

module ps2_digit_entry #(
    parameter int         NUM_DIGITS   = 7,
    parameter logic [3:0] PAD_NIBBLE   = 4'hA,
    parameter bit         REQUIRE_FULL = 1'b1
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    code_valid,
    input  logic [7:0]              code_byte,
    output logic [4*NUM_DIGITS-1:0] id_value,
    output logic [3:0]              digit_count,
    output logic                    full,
    output logic                    key_valid,
    output logic [3:0]              key_value,
    output logic                    entry_done,
    output logic                    esc_pulse,
    output logic                    ctrla_pulse,
    output logic                    err_pulse,
    output logic                    ctrl_held
);

    localparam logic [3:0] L_NUM = 4'(NUM_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t                  r_state;
    logic [8:0]              r_held_code;    // {ext, code} of the key currently held
    logic [4*NUM_DIGITS-1:0] r_id_value;
    logic [3:0]              r_digit_count;
    logic [3:0]              r_key_value;
    logic                    r_key_valid;
    logic                    r_entry_done;
    logic                    r_esc_pulse;
    logic                    r_ctrla_pulse;
    logic                    r_err_pulse;
    logic                    r_ctrl_held;

    state_t     w_state_nxt;
    logic       w_make;
    logic       w_break;
    logic       w_ext;
    logic       w_prefix;
    logic [8:0] w_code;
    logic [4:0] w_digit;        // {valid, value}
    logic       w_full;
    logic       w_enter_ok;
    logic [3:0] w_wr_idx;
    logic [3:0] w_bs_idx;

    // Main-row and keypad digit scan codes; {1, value} when the byte is a digit.
    function automatic logic [4:0] f_digit(input logic [7:0] c);
        case (c)
            8'h45, 8'h70: return {1'b1, 4'd0};
            8'h16, 8'h69: return {1'b1, 4'd1};
            8'h1E, 8'h72: return {1'b1, 4'd2};
            8'h26, 8'h7A: return {1'b1, 4'd3};
            8'h25, 8'h6B: return {1'b1, 4'd4};
            8'h2E, 8'h73: return {1'b1, 4'd5};
            8'h36, 8'h74: return {1'b1, 4'd6};
            8'h3D, 8'h6C: return {1'b1, 4'd7};
            8'h3E, 8'h75: return {1'b1, 4'd8};
            8'h46, 8'h7D: return {1'b1, 4'd9};
            default:      return 5'd0;
        endcase
    endfunction

    assign w_prefix = (code_byte == 8'hE0) || (code_byte == 8'hF0);

    always_comb begin
        w_state_nxt = S_IDLE;
        w_make      = 1'b0;
        w_break     = 1'b0;
        w_ext       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (code_byte == 8'hE0)      w_state_nxt = S_EXT;
                else if (code_byte == 8'hF0) w_state_nxt = S_BRK;
                else                         w_make      = 1'b1;
            end
            S_EXT: begin
                w_ext = 1'b1;
                if (code_byte == 8'hF0) w_state_nxt = S_EXT_BRK;
                else                    w_make      = 1'b1;
            end
            S_BRK: begin
                // A prefix here means a corrupted sequence: drop it.
                w_break = !w_prefix;
            end
            S_EXT_BRK: begin
                w_ext   = 1'b1;
                w_break = !w_prefix;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_code     = {w_ext, code_byte};
    assign w_digit    = f_digit(code_byte);
    assign w_full     = (r_digit_count == L_NUM);
    assign w_enter_ok = REQUIRE_FULL ? w_full : (r_digit_count != 4'd0);
    assign w_wr_idx   = L_NUM - 4'd1 - r_digit_count;
    assign w_bs_idx   = L_NUM - r_digit_count;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_held_code   <= '0;
            r_id_value    <= {NUM_DIGITS{PAD_NIBBLE}};
            r_digit_count <= 4'd0;
            r_key_value   <= 4'hF;
            r_key_valid   <= 1'b0;
            r_entry_done  <= 1'b0;
            r_esc_pulse   <= 1'b0;
            r_ctrla_pulse <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_ctrl_held   <= 1'b0;
        end else begin
            r_key_valid   <= 1'b0;
            r_entry_done  <= 1'b0;
            r_esc_pulse   <= 1'b0;
            r_ctrla_pulse <= 1'b0;
            r_err_pulse   <= 1'b0;
            if (code_valid) begin
                r_state <= w_state_nxt;
                if (w_make) begin
                    // Ctrl is tracked separately so Ctrl+A is not blocked as a repeat.
                    if (code_byte == 8'h14) begin
                        r_ctrl_held <= 1'b1;
                    end else if (w_code != r_held_code) begin
                        r_held_code <= w_code;
                        if (!w_ext && w_digit[4]) begin
                            if (w_full) begin
                                r_err_pulse <= 1'b1;
                            end else begin
                                for (int i = 0; i < NUM_DIGITS; i++) begin
                                    if (4'(i) == w_wr_idx) r_id_value[i*4 +: 4] <= w_digit[3:0];
                                end
                                r_digit_count <= r_digit_count + 4'd1;
                                r_key_valid   <= 1'b1;
                                r_key_value   <= w_digit[3:0];
                            end
                        end else if (!w_ext && code_byte == 8'h66) begin
                            if (r_digit_count == 4'd0) begin
                                r_err_pulse <= 1'b1;
                            end else begin
                                for (int i = 0; i < NUM_DIGITS; i++) begin
                                    if (4'(i) == w_bs_idx) r_id_value[i*4 +: 4] <= PAD_NIBBLE;
                                end
                                r_digit_count <= r_digit_count - 4'd1;
                            end
                        end else if (!w_ext && code_byte == 8'h76) begin
                            r_id_value    <= {NUM_DIGITS{PAD_NIBBLE}};
                            r_digit_count <= 4'd0;
                            r_key_value   <= 4'hF;
                            r_esc_pulse   <= 1'b1;
                        end else if (code_byte == 8'h5A) begin
                            if (w_enter_ok) r_entry_done <= 1'b1;
                            else            r_err_pulse  <= 1'b1;
                        end else if (!w_ext && code_byte == 8'h1C && r_ctrl_held) begin
                            r_ctrla_pulse <= 1'b1;
                        end
                    end
                end else if (w_break) begin
                    if (code_byte == 8'h14)         r_ctrl_held <= 1'b0;
                    else if (w_code == r_held_code) r_held_code <= '0;
                end
            end
        end
    end

    assign id_value    = r_id_value;
    assign digit_count = r_digit_count;
    assign full        = w_full;
    assign key_valid   = r_key_valid;
    assign key_value   = r_key_value;
    assign entry_done  = r_entry_done;
    assign esc_pulse   = r_esc_pulse;
    assign ctrla_pulse = r_ctrla_pulse;
    assign err_pulse   = r_err_pulse;
    assign ctrl_held   = r_ctrl_held;

endmodule

// File: tb/tb_ps2_digit_entry.sv
// tb_ps2_digit_entry
//   Directed byte sequences drive ps2_digit_entry. A queue-based model of the
//   ID entry runs beside the DUT. Every cycle, one compare process checks all
//   of the DUT outputs against that model. Literal checks at the end of each
//   sequence pin the model's results.

module tb_ps2_digit_entry;

    localparam int N = 7;

    logic           CLK;
    logic           reset;
    logic           code_valid;
    logic [7:0]     code_byte;
    logic [4*N-1:0] id_value;
    logic [3:0]     digit_count;
    logic           full;
    logic           key_valid;
    logic [3:0]     key_value;
    logic           entry_done;
    logic           esc_pulse;
    logic           ctrla_pulse;
    logic           err_pulse;
    logic           ctrl_held;

    ps2_digit_entry #(.NUM_DIGITS(N), .PAD_NIBBLE(4'hA), .REQUIRE_FULL(1'b1)) dut (
        .CLK(CLK), .reset(reset), .code_valid(code_valid), .code_byte(code_byte),
        .id_value(id_value), .digit_count(digit_count), .full(full),
        .key_valid(key_valid), .key_value(key_value), .entry_done(entry_done),
        .esc_pulse(esc_pulse), .ctrla_pulse(ctrla_pulse), .err_pulse(err_pulse),
        .ctrl_held(ctrl_held)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int kv_cnt = 0, done_cnt = 0, esc_cnt = 0, ca_cnt = 0, err_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the entered digits live in a queue, and the ID is rebuilt from it.
    int         m_q[$];
    bit         m_pend_ext, m_pend_brk;
    bit [8:0]   m_held;
    bit         m_ctrl;
    logic [3:0] m_key;
    bit         m_kv, m_done, m_esc, m_ca, m_err;

    function automatic int digit_of(input logic [7:0] b);
        case (b)
            8'h45, 8'h70: return 0;
            8'h16, 8'h69: return 1;
            8'h1E, 8'h72: return 2;
            8'h26, 8'h7A: return 3;
            8'h25, 8'h6B: return 4;
            8'h2E, 8'h73: return 5;
            8'h36, 8'h74: return 6;
            8'h3D, 8'h6C: return 7;
            8'h3E, 8'h75: return 8;
            8'h46, 8'h7D: return 9;
            default:      return -1;
        endcase
    endfunction

    function automatic logic [4*N-1:0] m_id();
        logic [4*N-1:0] v = '0;
        for (int i = 0; i < N; i++)
            v = (v << 4) | ((i < m_q.size()) ? 4'(m_q[i]) : 4'hA);
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend_ext = 0; m_pend_brk = 0; m_held = 0; m_ctrl = 0; m_key = 4'hF;
        m_kv = 0; m_done = 0; m_esc = 0; m_ca = 0; m_err = 0;
    endtask

    task automatic model_make(input bit ext, input logic [7:0] b);
        int d;
        if (b == 8'h14) begin m_ctrl = 1; return; end
        if ({ext, b} == m_held) return;
        m_held = {ext, b};
        d = ext ? -1 : digit_of(b);
        if (d >= 0) begin
            if (m_q.size() == N) m_err = 1;
            else begin m_q.push_back(d); m_kv = 1; m_key = 4'(d); end
        end else if (!ext && b == 8'h66) begin
            if (m_q.size() == 0) m_err = 1;
            else void'(m_q.pop_back());
        end else if (!ext && b == 8'h76) begin
            m_q.delete(); m_key = 4'hF; m_esc = 1;
        end else if (b == 8'h5A) begin
            if (m_q.size() == N) m_done = 1;
            else m_err = 1;
        end else if (!ext && b == 8'h1C && m_ctrl) begin
            m_ca = 1;
        end
    endtask

    task automatic model_step(input logic [7:0] b);
        if (m_pend_brk) begin
            if (b != 8'hE0 && b != 8'hF0) begin
                if (b == 8'h14) m_ctrl = 0;
                else if ({m_pend_ext, b} == m_held) m_held = 0;
            end
            m_pend_brk = 0; m_pend_ext = 0;
        end else if (m_pend_ext) begin
            if (b == 8'hF0) m_pend_brk = 1;
            else begin model_make(1, b); m_pend_ext = 0; end
        end else if (b == 8'hE0) m_pend_ext = 1;
        else if (b == 8'hF0) m_pend_brk = 1;
        else model_make(0, b);
    endtask

    // Inputs change on the falling edge; the model then holds what the outputs
    // must be after the next rising edge.
    task automatic send(input logic [7:0] b);
        code_valid = 1'b1;
        code_byte  = b;
        model_step(b);
        @(negedge CLK);
        code_valid = 1'b0;
        code_byte  = 8'h00;
        m_kv = 0; m_done = 0; m_esc = 0; m_ca = 0; m_err = 0;
    endtask

    task automatic send_seq(input logic [7:0] s[]);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic clr_cnt();
        kv_cnt = 0; done_cnt = 0; esc_cnt = 0; ca_cnt = 0; err_cnt = 0;
    endtask

    always @(posedge CLK) begin
        #2;
        chk("id_value",    id_value,    m_id());
        chk("digit_count", digit_count, 4'(m_q.size()));
        chk("full",        full,        m_q.size() == N);
        chk("key_valid",   key_valid,   m_kv);
        chk("key_value",   key_value,   m_key);
        chk("entry_done",  entry_done,  m_done);
        chk("esc_pulse",   esc_pulse,   m_esc);
        chk("ctrla_pulse", ctrla_pulse, m_ca);
        chk("err_pulse",   err_pulse,   m_err);
        chk("ctrl_held",   ctrl_held,   m_ctrl);
        if (key_valid)   kv_cnt++;
        if (entry_done)  done_cnt++;
        if (esc_pulse)   esc_cnt++;
        if (ctrla_pulse) ca_cnt++;
        if (err_pulse)   err_cnt++;
    end

    initial begin
        reset = 1'b1; code_valid = 1'b0; code_byte = 8'h00;
        model_reset();
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        chk("rst_id",    id_value,    28'hAAAAAAA);
        chk("rst_count", digit_count, 4'd0);
        chk("rst_key",   key_value,   4'hF);

        // Three digits, each with a break.
        clr_cnt();
        send_seq('{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26});
        chk("s1_id", id_value, 28'h123AAAA);
        chk("s1_count", digit_count, 4'd3);
        chk("s1_kv_pulses", kv_cnt, 3);
        chk("s1_key", key_value, 4'd3);
        send_seq('{8'h76, 8'hF0, 8'h76});

        // Typematic repeat.
        clr_cnt();
        send_seq('{8'h25, 8'h25, 8'h25, 8'hF0, 8'h25});
        chk("s2_kv_pulses", kv_cnt, 1);
        chk("s2_id", id_value, 28'h4AAAAAA);
        chk("s2_count", digit_count, 4'd1);
        send_seq('{8'h76, 8'hF0, 8'h76});

        // Fill, overflow, enter, backspace.
        clr_cnt();
        send_seq('{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26,
                   8'h25, 8'hF0, 8'h25, 8'h2E, 8'hF0, 8'h2E, 8'h36, 8'hF0, 8'h36,
                   8'h3D, 8'hF0, 8'h3D});
        chk("s3_full", full, 1'b1);
        send(8'h16);
        chk("s3_err_pulses", err_cnt, 1);
        chk("s3_id_full", id_value, 28'h1234567);
        send(8'h5A);
        chk("s3_done_pulses", done_cnt, 1);
        chk("s3_id_held", id_value, 28'h1234567);
        send(8'h66);
        chk("s3_id_bs", id_value, 28'h123456A);
        chk("s3_count_bs", digit_count, 4'd6);
        send_seq('{8'h76, 8'hF0, 8'h76});

        // Keypad Enter with a partial ID, then Esc.
        clr_cnt();
        send_seq('{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'hE0, 8'h5A});
        chk("s4_err_pulses", err_cnt, 1);
        chk("s4_done_pulses", done_cnt, 0);
        send(8'h76);
        chk("s4_esc_pulses", esc_cnt, 1);
        chk("s4_id", id_value, 28'hAAAAAAA);
        chk("s4_count", digit_count, 4'd0);
        send_seq('{8'hF0, 8'h76});

        // Right Ctrl + A, then release both and press A alone.
        clr_cnt();
        send_seq('{8'hE0, 8'h14, 8'h1C});
        chk("s5_ca_pulses", ca_cnt, 1);
        chk("s5_count", digit_count, 4'd0);
        send_seq('{8'hE0, 8'hF0, 8'h14, 8'hF0, 8'h1C, 8'h1C});
        chk("s5_ca_pulses_after", ca_cnt, 1);
        chk("s5_ctrl", ctrl_held, 1'b0);
        send_seq('{8'hF0, 8'h1C});

        // Backspace on empty, extended digit ignored, aborted break, keypad digit.
        clr_cnt();
        send_seq('{8'h66, 8'hF0, 8'h66, 8'hE0, 8'h69, 8'hE0, 8'hF0, 8'h69,
                   8'hF0, 8'hE0, 8'h7D, 8'hF0, 8'h7D});
        chk("s6_err_pulses", err_cnt, 1);
        chk("s6_id", id_value, 28'h9AAAAAA);
        send_seq('{8'h76, 8'hF0, 8'h76});

        // Asynchronous reset mid-sequence.
        send_seq('{8'h16, 8'hE0});
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("s7_rst_id", id_value, 28'hAAAAAAA);
        chk("s7_rst_count", digit_count, 4'd0);
        chk("s7_rst_key", key_value, 4'hF);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        send(8'h6B);
        chk("s7_id", id_value, 28'h4AAAAAA);
        chk("s7_count", digit_count, 4'd1);
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_digit_entry.md
Name: ps2_digit_entry

Overview:
- Parametrised successor to the single-ID PS/2 keypad capture block.
- Consumes the raw scan-code byte stream from the PS/2 receiver: one strobe per received byte.
- Builds a left-aligned BCD ID of NUM_DIGITS digits, with backspace, clear, enter and Ctrl+A commands.
- Decodes make/break (F0) and extended (E0) prefixes, and suppresses typematic repeats. Sits between ps2_keyboard and the game/lock FSMs.

Parameters:
- NUM_DIGITS, 7, ID length in digits (2..15).
- PAD_NIBBLE, 4'hA, value held in unfilled digit positions.
- REQUIRE_FULL, 1, 1 = Enter accepted only when all digits are entered; 0 = Enter accepted with at least 1 digit.

Ports:
- CLK  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- code_valid  in  1  one-cycle strobe; code_byte is valid.
- code_byte  in  8  received scan-code byte.
- id_value  out  4*NUM_DIGITS  digits; first entered digit in MS nibble.
- digit_count  out  4  number of digits entered (0..NUM_DIGITS).
- full  out  1  digit_count == NUM_DIGITS.
- key_valid  out  1  one-cycle pulse on a newly accepted digit.
- key_value  out  4  last accepted digit (0..9); 4'hF after reset or clear.
- entry_done  out  1  one-cycle pulse on accepted Enter.
- esc_pulse  out  1  one-cycle pulse on Esc.
- ctrla_pulse  out  1  one-cycle pulse on A make while Ctrl is held.
- err_pulse  out  1  one-cycle pulse on a rejected action.
- ctrl_held  out  1  a Ctrl key (14 or E0 14) is currently down.

Behaviour:
- Reset is asynchronous, active-high; clock is CLK. Reset values:
  - id_value = all PAD_NIBBLE; digit_count = 0; key_value = 4'hF.
  - All pulse outputs = 0; ctrl_held = 0.
  - Parser in S_IDLE; held_code = 8'h00.
- Bytes are processed only on code_valid cycles. All outputs are registered; a pulse appears 1 cycle after the code_valid that completes the sequence.
- Parser FSM:
  - S_IDLE: E0 -> S_EXT; F0 -> S_BRK; any other byte = normal make event, stay in S_IDLE.
  - S_EXT: F0 -> S_EXT_BRK; any other byte = extended make event -> S_IDLE.
  - S_BRK: byte = normal break event -> S_IDLE.
  - S_EXT_BRK: byte = extended break event -> S_IDLE.
  - Byte E0 or F0 received in S_BRK or S_EXT_BRK: discard the sequence, go to S_IDLE.
- Typematic suppression:
  - A make event whose code (including the ext flag) equals held_code is ignored.
  - Otherwise the make is executed and held_code takes that code.
  - A break event whose code equals held_code sets held_code = 0.
  - Ctrl make/break events do not touch held_code.
- Digit codes (normal only): 45/70=0, 16/69=1, 1E/72=2, 26/7A=3, 25/6B=4, 2E/73=5, 36/74=6, 3D/6C=7, 3E/75=8, 46/7D=9. Extended versions of these codes are arrow/nav keys and are ignored.
- Digit make:
  - Not full: write the digit into nibble index (NUM_DIGITS-1-digit_count) counted from LSB; increment digit_count; pulse key_valid; update key_value.
  - Full: no change to id_value or digit_count; pulse err_pulse.
- Backspace (66, normal):
  - digit_count > 0: restore the nibble at index (NUM_DIGITS-digit_count) to PAD_NIBBLE; decrement digit_count.
  - digit_count = 0: pulse err_pulse.
- Esc (76, normal): all nibbles = PAD_NIBBLE; digit_count = 0; key_value = F; pulse esc_pulse.
- Enter (5A, normal or extended):
  - Accepted if (REQUIRE_FULL ? full : digit_count > 0): pulse entry_done; id_value is held until the next digit, Backspace or Esc.
  - Otherwise: pulse err_pulse.
- Ctrl: 14 or E0 14 make sets ctrl_held; matching break clears it.
- A (1C, normal) make:
  - ctrl_held = 1: pulse ctrla_pulse; no digit action.
  - ctrl_held = 0: ignored.
- All other codes are ignored.
- At most one action per code_valid. Pulses never last longer than 1 cycle.
- Reset mid-sequence (after an E0/F0 prefix) returns the parser to S_IDLE; the next byte is treated as a fresh sequence.

Test Plan:
- Bytes 16,F0,16,1E,F0,1E,26,F0,26 (NUM_DIGITS=7) -> id_value 0x123AAAA, digit_count 3, three key_valid pulses, key_value 3.
- Bytes 25,25,25,F0,25 (typematic repeat) -> exactly one key_valid; id_value 0x4AAAAAA, digit_count 1.
- Enter 7 digits 1..7, then 16 -> err_pulse; id_value stays 0x1234567. Then 5A -> entry_done. Then 66 -> id_value 0x123456A, count 6.
- With 2 digits entered, bytes E0,5A (REQUIRE_FULL=1) -> err_pulse, no entry_done; byte 76 -> esc_pulse, id_value 0xAAAAAAA, count 0.
- Bytes E0,14,1C -> ctrla_pulse, digit_count unchanged. Then E0,F0,14,F0,1C,1C -> no second ctrla_pulse; ctrl_held 0.
- Bytes 16,E0, then reset asserted mid-cycle (async), released, then 6B -> outputs at reset values before the 6B; after the 6B, id_value 0x4AAAAAA (not treated as extended).
